wait_state_data_memory: RTL

WAIT_STATE_DATA_MEMORY -- requirements
Module: wait_state_data_memory

---
 rtl/wait_state_data_memory.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/wait_state_data_memory.sv
// Byte-addressed big-endian data memory with a fixed number of wait states per access.
// Optional macro WSDM_ALIGN_CHECK_EN turns misaligned halfword/word requests into errors.
module wait_state_data_memory #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error
);

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam bit          ZERO_WAIT = (WAIT_STATES == 0);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;

    logic [7:0] mem [DEPTH];

    logic                  cap_write;
    logic [1:0]            cap_size;
    logic                  cap_unsigned;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [31:0]           cap_wdata;

    logic                  accept;
    logic                  req_err;
    logic                  misalign;
    logic                  hs;
    logic                  wait_done;
    logic                  do_access;

    logic                  acc_write;
    logic [1:0]            acc_size;
    logic                  acc_unsigned;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [31:0]           acc_wdata;

    logic [ADDR_WIDTH-1:0] a0;
    logic [ADDR_WIDTH-1:0] a1;
    logic [ADDR_WIDTH-1:0] a2;
    logic [ADDR_WIDTH-1:0] a3;
    logic [7:0]            b0;
    logic [7:0]            b1;
    logic [7:0]            b2;
    logic [7:0]            b3;
    logic [31:0]           load_data;

    logic                  next_req_ready;
    logic                  next_resp_valid;
    logic                  next_resp_error;
    logic [31:0]           next_resp_rdata;

    // Request classification, evaluated on the live request at acceptance
    always_comb begin
        misalign = 1'b0;
`ifdef WSDM_ALIGN_CHECK_EN
        if (req_size == SZ_HALF && req_addr[0]) begin
            misalign = 1'b1;
        end
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) begin
            misalign = 1'b1;
        end
`endif
        req_err = (req_size == 2'd3) || misalign;
    end

    assign accept    = (state == S_IDLE) && req_valid;
    assign hs        = (state == S_RESP) && resp_ready;
    assign wait_done = (state == S_WAIT) && (cnt == CNT_W'(1));
    assign do_access = !reset && ((accept && !req_err && ZERO_WAIT) || wait_done);

    // Zero-wait accesses use the live request; otherwise the captured copy
    always_comb begin
        if (state == S_IDLE) begin
            acc_write    = req_write;
            acc_size     = req_size;
            acc_unsigned = req_unsigned;
            acc_addr     = req_addr;
            acc_wdata    = req_wdata;
        end else begin
            acc_write    = cap_write;
            acc_size     = cap_size;
            acc_unsigned = cap_unsigned;
            acc_addr     = cap_addr;
            acc_wdata    = cap_wdata;
        end
    end

    // Misaligned halfword/word addresses are rounded down to their natural boundary
    always_comb begin
        a0 = acc_addr;
        case (acc_size)
            SZ_HALF: a0 = {acc_addr[ADDR_WIDTH-1:1], 1'b0};
            SZ_WORD: a0 = {acc_addr[ADDR_WIDTH-1:2], 2'b00};
            default: a0 = acc_addr;
        endcase
        a1 = a0 + ADDR_WIDTH'(1);
        a2 = a0 + ADDR_WIDTH'(2);
        a3 = a0 + ADDR_WIDTH'(3);
    end

    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    // Big-endian assembly: lowest address is the most significant byte
    always_comb begin
        load_data = 32'd0;
        case (acc_size)
            SZ_BYTE: load_data = {{24{b0[7] & !acc_unsigned}}, b0};
            SZ_HALF: load_data = {{16{b0[7] & !acc_unsigned}}, b0, b1};
            SZ_WORD: load_data = {b0, b1, b2, b3};
            default: load_data = 32'd0;
        endcase
    end

    // Storage array; never reset so contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (do_access && acc_write) begin
            case (acc_size)
                SZ_BYTE: begin
                    mem[a0] <= acc_wdata[7:0];
                end
                SZ_HALF: begin
                    mem[a0] <= acc_wdata[15:8];
                    mem[a1] <= acc_wdata[7:0];
                end
                SZ_WORD: begin
                    mem[a0] <= acc_wdata[31:24];
                    mem[a1] <= acc_wdata[23:16];
                    mem[a2] <= acc_wdata[15:8];
                    mem[a3] <= acc_wdata[7:0];
                end
                default: begin
                end
            endcase
        end
    end

    // State, counter, captured request and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            cap_write    <= 1'b0;
            cap_size     <= 2'd0;
            cap_unsigned <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= 32'd0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_error   <= 1'b0;
            resp_rdata   <= 32'd0;
        end else begin
            state      <= next_state;
            cnt        <= next_cnt;
            req_ready  <= next_req_ready;
            resp_valid <= next_resp_valid;
            resp_error <= next_resp_error;
            resp_rdata <= next_resp_rdata;
            if (accept) begin
                cap_write    <= req_write;
                cap_size     <= req_size;
                cap_unsigned <= req_unsigned;
                cap_addr     <= req_addr;
                cap_wdata    <= req_wdata;
            end
        end
    end

    // Next-state and wait counter
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err || ZERO_WAIT) begin
                        next_state = S_RESP;
                    end else begin
                        next_state = S_WAIT;
                        next_cnt   = CNT_W'(WAIT_STATES);
                    end
                end
            end
            S_WAIT: begin
                next_cnt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // Output values to be registered alongside the state
    always_comb begin
        next_req_ready  = (next_state == S_IDLE);
        next_resp_valid = (next_state == S_RESP);
        next_resp_error = resp_error;
        next_resp_rdata = resp_rdata;
        if (accept && req_err) begin
            next_resp_error = 1'b1;
            next_resp_rdata = 32'd0;
        end else if (do_access) begin
            next_resp_error = 1'b0;
            next_resp_rdata = acc_write ? 32'd0 : load_data;
        end
        if (hs) begin
            next_resp_error = 1'b0;
            next_resp_rdata = 32'd0;
        end
    end

endmodule
